sro_dout_receiver: RTL and testbench

- Back-end receiver and checker for the simple-readout serial-parallel output word stream `dout[29:0]`.
- It mirrors the trigger side:
  - captures each L1A together with its 16-bit ROI mask and the local BCID;
  - reassembles the returned pixel words into one event record per L1A;
  - flags missing, misordered, wrong-BCID and unexpected words.
- It sits beside the readout block in the DAQ-side test harness and in FPGA firmware, fed by the same clock, `bc0`, `l1acc` and `roi`.

---
 rtl/sro_dout_receiver_pkg.sv | 14 +
 rtl/sro_dout_receiver_if.sv | 32 +++
 rtl/sro_rx_pend_fifo.sv | 50 +++++
 rtl/sro_dout_receiver.sv | 180 ++++++++++++++++++
 tb/tb_sro_dout_receiver.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sro_dout_receiver_pkg.sv
// Shared constants and state encoding for the simple-readout dout receiver.
package sro_rx_pkg;
  localparam int VALID_BIT   = 29;
  localparam int R_MSB       = 27;
  localparam int C_MSB       = 23;
  localparam int BCID_W      = 20;
  localparam int ROI_W       = 16;
  localparam int REC_W       = ROI_W + BCID_W;
  localparam int ERR_TIMEOUT = 3;
  localparam int ERR_ORDER   = 2;
  localparam int ERR_BCID    = 1;

  typedef enum logic [1:0] {IDLE, LOAD, RECV, DONE} state_e;
endpackage

// File: rtl/sro_dout_receiver_if.sv
// Trigger/stream inputs and event-record outputs of the dout receiver.
// Stats ports exist only with SRO_DOUT_RECEIVER_STATS_EN.
interface sro_dout_receiver_if;
  logic        bc0;
  logic        l1acc;
  logic [15:0] roi;
  logic [29:0] dout;
  logic        evt_done;
  logic        evt_ok;
  logic [4:0]  evt_nwords;
  logic [19:0] evt_bcid;
  logic [3:0]  evt_err;
  logic        unexp;
  logic        overflow;
  logic        busy;
`ifdef SRO_DOUT_RECEIVER_STATS_EN
  logic [15:0] stat_events;
  logic [15:0] stat_errors;
  logic [23:0] stat_words;
  modport slave (input bc0, l1acc, roi, dout,
                 output evt_done, evt_ok, evt_nwords, evt_bcid, evt_err, unexp, overflow, busy,
                 output stat_events, stat_errors, stat_words);
  modport master (output bc0, l1acc, roi, dout,
                  input evt_done, evt_ok, evt_nwords, evt_bcid, evt_err, unexp, overflow, busy,
                  input stat_events, stat_errors, stat_words);
`else
  modport slave (input bc0, l1acc, roi, dout,
                 output evt_done, evt_ok, evt_nwords, evt_bcid, evt_err, unexp, overflow, busy);
  modport master (output bc0, l1acc, roi, dout,
                  input evt_done, evt_ok, evt_nwords, evt_bcid, evt_err, unexp, overflow, busy);
`endif
endinterface

// File: rtl/sro_rx_pend_fifo.sv
// Pending-L1A queue; a push into a full queue is accepted only alongside a pop.
module sro_rx_pend_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         push_acc
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]               wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
  logic                      do_pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign push_acc = push && (!full || do_pop);
  assign dout     = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_acc) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/sro_dout_receiver.sv
// Reassembles dout pixel words into one checked record per L1A.
// Optional saturating statistics: SRO_DOUT_RECEIVER_STATS_EN.
module sro_dout_receiver
  import sro_rx_pkg::*;
#(
  parameter int                PEND_DEPTH  = 4,
  parameter int                TIMEOUT     = 1024,
  parameter logic [BCID_W-1:0] BCID_OFFSET = '0
) (
  input logic                clock,
  input logic                reset,
  sro_dout_receiver_if.slave io
);
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_e              state_q, state_d;
  logic [BCID_W-1:0]   bcid_q, bcid_d, exp_bcid_q, exp_bcid_d;
  logic [ROI_W-1:0]    mask_q, mask_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [4:0]          nw_q, nw_d, rec_nw_q, rec_nw_d;
  logic [3:0]          err_q, err_d, rec_err_q, rec_err_d;
  logic [BCID_W-1:0]   rec_bcid_q, rec_bcid_d;
  logic                done_q, done_d, ok_q, ok_d, unexp_q, unexp_d, ovf_q, ovf_d;

  logic                pop, f_full, f_empty, push_acc;
  logic [REC_W-1:0]    f_dout;
  logic [ROI_W-1:0]    f_roi, lowest, pix_hot;
  logic [3:0]          w_r, w_c;
  logic                is_data, unused_rsvd;

  sro_rx_pend_fifo #(.DEPTH(PEND_DEPTH), .W(REC_W)) u_pend (
    .clock(clock), .reset(reset),
    .push(io.l1acc), .din({io.roi, bcid_q + BCID_OFFSET}),
    .pop(pop), .dout(f_dout), .full(f_full), .empty(f_empty), .push_acc(push_acc)
  );

  assign f_roi       = f_dout[REC_W-1:BCID_W];
  assign is_data     = io.dout[VALID_BIT];
  assign unused_rsvd = io.dout[VALID_BIT-1];
  assign w_r         = io.dout[R_MSB -: 4];
  assign w_c         = io.dout[C_MSB -: 4];
  // One-hot compare avoids an encoder: lowest remaining bit vs. decoded {R,C}.
  assign lowest      = mask_q & (~mask_q + 1'b1);
  assign pix_hot     = (w_r[3:2] == 2'b00 && w_c[3:2] == 2'b00)
                       ? (ROI_W'(1) << {w_r[1:0], w_c[1:0]}) : '0;

  always_comb begin
    state_d    = state_q;
    bcid_d     = io.bc0 ? '0 : bcid_q + 1'b1;
    exp_bcid_d = exp_bcid_q;
    mask_d     = mask_q;
    timer_d    = timer_q;
    nw_d       = nw_q;
    err_d      = err_q;
    rec_nw_d   = rec_nw_q;
    rec_err_d  = rec_err_q;
    rec_bcid_d = rec_bcid_q;
    ok_d       = ok_q;
    done_d     = 1'b0;
    unexp_d    = 1'b0;
    ovf_d      = ovf_q | (io.l1acc & ~push_acc);
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        unexp_d = is_data;
        if (!f_empty) state_d = LOAD;
      end
      LOAD: begin
        unexp_d    = is_data;
        pop        = 1'b1;
        mask_d     = f_roi;
        exp_bcid_d = f_dout[BCID_W-1:0];
        timer_d    = '0;
        nw_d       = '0;
        err_d      = '0;
        state_d    = (f_roi == '0) ? DONE : RECV;
      end
      RECV: begin
        timer_d = timer_q + 1'b1;
        if (is_data) begin
          if (pix_hot != lowest) err_d[ERR_ORDER] = 1'b1;
          if (io.dout[BCID_W-1:0] != exp_bcid_q) err_d[ERR_BCID] = 1'b1;
          mask_d = mask_q & ~lowest;
          nw_d   = nw_q + 1'b1;
        end
        if (mask_d == '0) state_d = DONE;
        else if (timer_d == TW'(TIMEOUT - 1)) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        unexp_d = is_data;
        state_d = f_empty ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
    // Record is latched on entry to DONE and held until the next event.
    if (state_d == DONE) begin
      done_d     = 1'b1;
      ok_d       = (err_d == '0);
      rec_nw_d   = nw_d;
      rec_err_d  = err_d;
      rec_bcid_d = exp_bcid_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bcid_q     <= '0;
      exp_bcid_q <= '0;
      mask_q     <= '0;
      timer_q    <= '0;
      nw_q       <= '0;
      err_q      <= '0;
      rec_nw_q   <= '0;
      rec_err_q  <= '0;
      rec_bcid_q <= '0;
      ok_q       <= 1'b0;
      done_q     <= 1'b0;
      unexp_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcid_q     <= bcid_d;
      exp_bcid_q <= exp_bcid_d;
      mask_q     <= mask_d;
      timer_q    <= timer_d;
      nw_q       <= nw_d;
      err_q      <= err_d;
      rec_nw_q   <= rec_nw_d;
      rec_err_q  <= rec_err_d;
      rec_bcid_q <= rec_bcid_d;
      ok_q       <= ok_d;
      done_q     <= done_d;
      unexp_q    <= unexp_d;
      ovf_q      <= ovf_d;
    end
  end

  assign io.evt_done   = done_q;
  assign io.evt_ok     = ok_q;
  assign io.evt_nwords = rec_nw_q;
  assign io.evt_bcid   = rec_bcid_q;
  assign io.evt_err    = rec_err_q;
  assign io.unexp      = unexp_q;
  assign io.overflow   = ovf_q;
  assign io.busy       = (state_q != IDLE) || !f_empty;

`ifdef SRO_DOUT_RECEIVER_STATS_EN
  logic [15:0] sev_q, sev_d, ser_q, ser_d;
  logic [23:0] swd_q, swd_d;

  always_comb begin
    sev_d = sev_q;
    ser_d = ser_q;
    swd_d = swd_q;
    if (done_q && sev_q != '1) sev_d = sev_q + 1'b1;
    if (done_q && !ok_q && ser_q != '1) ser_d = ser_q + 1'b1;
    if (state_q == RECV && is_data && swd_q != '1) swd_d = swd_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sev_q <= '0;
      ser_q <= '0;
      swd_q <= '0;
    end else begin
      sev_q <= sev_d;
      ser_q <= ser_d;
      swd_q <= swd_d;
    end
  end

  assign io.stat_events = sev_q;
  assign io.stat_errors = ser_q;
  assign io.stat_words  = swd_q;
`endif
endmodule

// File: tb/tb_sro_dout_receiver.sv
// Directed bench for sro_dout_receiver: record contents, errors, timeout, overflow, reset.
module tb_sro_dout_receiver;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n, k;
  logic [19:0] tb_bcid;
  logic [19:0] eb, ea;
  logic [19:0] qb [4];

  sro_dout_receiver_if io ();

  sro_dout_receiver dut (.clock(clock), .reset(reset), .io(io));

  always #5 clock = ~clock;

  // Reference BCID: zero the cycle after bc0, else count up.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_bcid <= '0;
    else       tb_bcid <= io.bc0 ? 20'd0 : tb_bcid + 20'd1;
  end

  initial begin
    io.bc0 = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      io.bc0 = (cyc % 3557 == 0);
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the DUT in its first RECV cycle (or DONE when roi is empty).
  task automatic start_event(input logic [15:0] roi);
    eb       = tb_bcid;
    io.l1acc = 1'b1;
    io.roi   = roi;
    tick;
    io.l1acc = 1'b0;
    tick;
    tick;
  endtask

  task automatic send_word(input int p, input logic [19:0] b);
    logic [3:0] r, c;
    r = 4'(p / 4);
    c = 4'(p % 4);
    io.dout = {1'b1, 1'b0, r, c, b};
    tick;
    io.dout = '0;
  endtask

  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    do begin
      tick;
      cnt++;
    end while (!io.evt_done && cnt < budget);
    chk("done_seen", io.evt_done, 1);
  endtask

  task automatic chk_rec(input string tag, input int nw, input logic [19:0] b, input logic [3:0] e);
    chk({tag, "_done"},   io.evt_done, 1);
    chk({tag, "_ok"},     io.evt_ok, (e == 4'd0));
    chk({tag, "_nwords"}, io.evt_nwords, nw);
    chk({tag, "_bcid"},   io.evt_bcid, b);
    chk({tag, "_err"},    io.evt_err, e);
  endtask

  initial begin
    reset    = 1'b1;
    io.l1acc = 1'b0;
    io.roi   = '0;
    io.dout  = '0;
    tick;
    tick;
    chk("rst_done", io.evt_done, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_ovf",  io.overflow, 0);
    chk("rst_nw",   io.evt_nwords, 0);
    reset = 1'b0;
    repeat (20) tick;

    // single pixel R1 C2
    start_event(16'h0040);
    chk("t1_busy", io.busy, 1);
    send_word(6, eb);
    chk_rec("t1", 1, eb, 4'b0000);
    tick;
    chk("t1_pulse", io.evt_done, 0);
    chk("t1_hold",  io.evt_nwords, 1);

    // four pixels in order with idle gaps
    start_event(16'h2222);
    send_word(1, eb);  repeat (3) tick;
    send_word(5, eb);  repeat (3) tick;
    send_word(9, eb);  repeat (3) tick;
    chk("t2_early", io.evt_done, 0);
    send_word(13, eb);
    chk_rec("t2", 4, eb, 4'b0000);
    tick;

    // swapped order plus one wrong BCID
    start_event(16'h00f0);
    send_word(5, eb);
    send_word(4, eb + 20'd1);
    send_word(6, eb);
    send_word(7, eb);
    chk_rec("t3", 4, eb, 4'b0110);
    tick;

    // empty ROI completes right after LOAD
    start_event(16'h0000);
    chk_rec("t4", 0, eb, 4'b0000);
    tick;

    // partial event times out 1024 cycles after LOAD
    start_event(16'hffff);
    n = 3;
    for (int p = 0; p < 10; p++) begin
      send_word(p, eb);
      n++;
    end
    wait_done(1100, k);
    chk("t5_latency", n + k, 1026);
    chk_rec("t5", 10, eb, 4'b1000);
    tick;

    // five L1As while busy: four queued, one dropped
    start_event(16'h0001);
    ea = eb;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) qb[i] = tb_bcid;
      io.l1acc = 1'b1;
      io.roi   = 16'h0001;
      tick;
      io.l1acc = 1'b0;
      tick;
    end
    chk("t6_ovf", io.overflow, 1);
    send_word(0, ea);
    chk_rec("t6a", 1, ea, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      wait_done(1100, k);
      chk_rec("t6q", 0, qb[i], 4'b1000);
    end
    tick;
    chk("t6_idle_busy", io.busy, 0);
    chk("t6_ovf_sticky", io.overflow, 1);
    send_word(3, 20'd0);
    chk("t6_unexp", io.unexp, 1);
    tick;
    chk("t6_unexp_pulse", io.unexp, 0);

    // reset in RECV clears everything at once
    start_event(16'h0003);
    chk("t7_busy", io.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_done", io.evt_done, 0);
    chk("t7_ok",   io.evt_ok, 0);
    chk("t7_nw",   io.evt_nwords, 0);
    chk("t7_bcid", io.evt_bcid, 0);
    chk("t7_err",  io.evt_err, 0);
    chk("t7_unexp", io.unexp, 0);
    chk("t7_ovf",  io.overflow, 0);
    chk("t7_busy0", io.busy, 0);
    tick;
    reset = 1'b0;
    repeat (5) tick;
    start_event(16'h0008);
    send_word(3, eb);
    chk_rec("t8", 1, eb, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
